// File: rtl/l2_mem_pkg.sv
// rtl/l2_mem_pkg.sv - message types, header field positions and FSM states for l2_mem_responder
package l2_mem_pkg;

    localparam logic [7:0] MSG_STORE_MEM     = 8'h13;
    localparam logic [7:0] MSG_LOAD_MEM      = 8'h14;
    localparam logic [7:0] MSG_STORE_MEM_ACK = 8'h93;
    localparam logic [7:0] MSG_LOAD_MEM_ACK  = 8'h94;

    localparam int HDR_TYPE_LSB = 0;
    localparam int HDR_TYPE_MSB = 7;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_LEN_MSB  = 15;
    localparam int HDR_SRC_LSB  = 16;
    localparam int HDR_SRC_MSB  = 21;
    localparam int HDR_TAG_LSB  = 22;
    localparam int HDR_TAG_MSB  = 47;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_DATA,
        ST_DROP,
        ST_WAIT,
        ST_TX_HDR,
        ST_TX_DATA
    } state_t;

    function automatic logic [63:0] make_hdr(input logic [7:0]  msg_type,
                                             input logic [7:0]  len,
                                             input logic [5:0]  src,
                                             input logic [25:0] tag);
        logic [63:0] h;
        h = '0;
        h[HDR_TYPE_MSB:HDR_TYPE_LSB] = msg_type;
        h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        h[HDR_SRC_MSB:HDR_SRC_LSB]   = src;
        h[HDR_TAG_MSB:HDR_TAG_LSB]   = tag;
        return h;
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - 64-bit backing store: sync write, registered read, zeroed after reset
module mem_resp_array #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data,
    output logic          busy
);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] clr_idx;
    logic          clearing;

    always_ff @(posedge clk) begin
        if (rst) begin
            clearing <= 1'b1;
            clr_idx  <= '0;
            rd_data  <= '0;
        end else begin
            if (clearing) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_idx == AW'(DEPTH - 1)) begin
                    clearing <= 1'b0;
                end
            end
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    // Zeroing walks one entry per cycle and owns the write port until done.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign busy = clearing;

endmodule

// File: rtl/l2_mem_responder.sv
// rtl/l2_mem_responder.sv - L2 memory responder (NoC2 in, NoC3 out); MEM_RESP_DELAY_EN enables programmable WAIT
module l2_mem_responder
    import l2_mem_pkg::*;
#(
    parameter int MEM_DEPTH  = 16,
    parameter int RESP_DELAY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        noc2_valid_in,
    input  logic [63:0] noc2_data_in,
    output logic        noc2_ready_out,
    output logic        noc3_valid_out,
    output logic [63:0] noc3_data_out,
    input  logic        noc3_ready_in,
    output logic [7:0]  err_count
);

    localparam int AW = $clog2(MEM_DEPTH);

    if (MEM_DEPTH < 2 || MEM_DEPTH > 256 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("MEM_DEPTH must be a power of two in 2..256");
    end
    if (RESP_DELAY < 1 || RESP_DELAY > 255) begin : g_bad_delay
        $error("RESP_DELAY must be in 1..255");
    end

    state_t      state, state_next;
    logic [7:0]  typ_q;
    logic [5:0]  src_q;
    logic [25:0] tag_q;
    logic [7:0]  drop_left;
    logic        hdr_fire, wr_en, rd_en, busy, wait_done;
    logic [63:0] rd_data;

    logic [7:0]  in_type, in_len;
    logic [5:0]  in_src;
    logic [25:0] in_tag;
    logic        in_known, load_q;
    logic        unused_hdr_bits;

    assign in_type  = noc2_data_in[HDR_TYPE_MSB:HDR_TYPE_LSB];
    assign in_len   = noc2_data_in[HDR_LEN_MSB:HDR_LEN_LSB];
    assign in_src   = noc2_data_in[HDR_SRC_MSB:HDR_SRC_LSB];
    assign in_tag   = noc2_data_in[HDR_TAG_MSB:HDR_TAG_LSB];
    assign in_known = (in_type == MSG_STORE_MEM) || (in_type == MSG_LOAD_MEM);
    assign load_q   = (typ_q == MSG_LOAD_MEM);
    assign unused_hdr_bits = &{1'b0, noc2_data_in[63:48]};

`ifdef MEM_RESP_DELAY_EN
    logic [7:0] delay_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            delay_cnt <= '0;
        end else if (state != ST_WAIT && state_next == ST_WAIT) begin
            delay_cnt <= 8'(RESP_DELAY);
        end else if (state == ST_WAIT && delay_cnt != 8'd0) begin
            delay_cnt <= delay_cnt - 8'd1;
        end
    end

    assign wait_done = (delay_cnt == 8'd1);
`else
    assign wait_done = 1'b1;
`endif

    always_comb begin
        state_next     = state;
        noc2_ready_out = 1'b0;
        hdr_fire       = 1'b0;
        wr_en          = 1'b0;
        rd_en          = 1'b0;
        case (state)
            ST_IDLE: begin
                noc2_ready_out = !busy;
                if (noc2_valid_in && !busy) begin
                    hdr_fire = 1'b1;
                    if (in_type == MSG_STORE_MEM)     state_next = ST_RX_DATA;
                    else if (in_type == MSG_LOAD_MEM) state_next = ST_WAIT;
                    else if (in_len != 8'd0)          state_next = ST_DROP;
                end
            end
            ST_RX_DATA: begin
                noc2_ready_out = 1'b1;
                if (noc2_valid_in) begin
                    // A flit arriving alongside rst belongs to an abandoned store.
                    wr_en      = !rst;
                    state_next = ST_WAIT;
                end
            end
            ST_DROP: begin
                noc2_ready_out = 1'b1;
                if (noc2_valid_in && drop_left == 8'd1) state_next = ST_IDLE;
            end
            ST_WAIT: begin
                if (wait_done) begin
                    rd_en      = 1'b1;
                    state_next = ST_TX_HDR;
                end
            end
            ST_TX_HDR: begin
                if (noc3_ready_in) state_next = load_q ? ST_TX_DATA : ST_IDLE;
            end
            ST_TX_DATA: begin
                if (noc3_ready_in) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            noc3_valid_out <= 1'b0;
            noc3_data_out  <= '0;
            err_count      <= '0;
            typ_q          <= '0;
            src_q          <= '0;
            tag_q          <= '0;
            drop_left      <= '0;
        end else begin
            state          <= state_next;
            noc3_valid_out <= (state_next == ST_TX_HDR) || (state_next == ST_TX_DATA);
            if (hdr_fire) begin
                typ_q     <= in_type;
                src_q     <= in_src;
                tag_q     <= in_tag;
                drop_left <= in_len;
                if (!in_known && err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            if (state == ST_DROP && noc2_valid_in) drop_left <= drop_left - 8'd1;
            // Output flit is only reloaded on a state advance, so it holds under backpressure.
            if (rd_en) begin
                noc3_data_out <= make_hdr(load_q ? MSG_LOAD_MEM_ACK : MSG_STORE_MEM_ACK,
                                          load_q ? 8'd1 : 8'd0, src_q, tag_q);
            end else if (state == ST_TX_HDR && noc3_ready_in && load_q) begin
                noc3_data_out <= rd_data;
            end
        end
    end

    mem_resp_array #(
        .DEPTH(MEM_DEPTH),
        .AW   (AW)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(tag_q[AW-1:0]),
        .wr_data(noc2_data_in),
        .rd_en  (rd_en),
        .rd_addr(tag_q[AW-1:0]),
        .rd_data(rd_data),
        .busy   (busy)
    );

endmodule

// File: tb/tb_l2_mem_responder.sv
// tb/tb_l2_mem_responder.sv - randomized self-checking bench for l2_mem_responder
module tb_l2_mem_responder;

    localparam int MEM_DEPTH  = 16;
    localparam int RESP_DELAY = 4;
`ifdef MEM_RESP_DELAY_EN
    localparam int WAIT_CYC = RESP_DELAY;
`else
    localparam int WAIT_CYC = 1;
`endif
    localparam int LIMIT = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        noc2_valid_in;
    logic [63:0] noc2_data_in;
    logic        noc2_ready_out;
    logic        noc3_valid_out;
    logic [63:0] noc3_data_out;
    logic        noc3_ready_in;
    logic [7:0]  err_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] model_mem [MEM_DEPTH];
    int          model_err;

    l2_mem_responder #(
        .MEM_DEPTH (MEM_DEPTH),
        .RESP_DELAY(RESP_DELAY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .noc2_valid_in (noc2_valid_in),
        .noc2_data_in  (noc2_data_in),
        .noc2_ready_out(noc2_ready_out),
        .noc3_valid_out(noc3_valid_out),
        .noc3_data_out (noc3_data_out),
        .noc3_ready_in (noc3_ready_in),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] hdr(input int typ, input int len, input int src,
                                        input logic [25:0] tag);
        return 64'(typ) + (64'(len) << 8) + (64'(src) << 16) + (64'(tag) << 22);
    endfunction

    function automatic int idx(input logic [25:0] tag);
        return int'(tag) % MEM_DEPTH;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_flit(input logic [63:0] d);
        int n = 0;
        noc2_valid_in = 1'b1;
        noc2_data_in  = d;
        forever begin
            @(negedge clk);
            if (noc2_ready_out) break;
            n++;
            if (n > LIMIT) break;
        end
        if (n > LIMIT) check("send_timeout", 64'(n), 64'(LIMIT));
        @(posedge clk);
        #1;
        noc2_valid_in = 1'b0;
    endtask

    task automatic recv_flit(output logic [63:0] d, output int lat);
        lat = 0;
        d   = '0;
        noc3_ready_in = 1'b1;
        forever begin
            @(negedge clk);
            lat++;
            if (noc3_valid_out) begin
                d = noc3_data_out;
                break;
            end
            if (lat > LIMIT) break;
        end
        if (lat > LIMIT) check("recv_timeout", 64'(lat), 64'(LIMIT));
        @(posedge clk);
        #1;
        noc3_ready_in = 1'b0;
    endtask

    task automatic do_store(input string name, input logic [25:0] tag, input logic [5:0] src,
                            input logic [63:0] d);
        logic [63:0] got;
        int lat;
        send_flit(hdr(8'h13, 1, int'(src), tag));
        send_flit(d);
        model_mem[idx(tag)] = d;
        recv_flit(got, lat);
        check({name, "_ack_hdr"}, got, hdr(8'h93, 0, int'(src), tag));
        check({name, "_ack_lat"}, 64'(lat), 64'(WAIT_CYC + 1));
    endtask

    task automatic do_load(input string name, input logic [25:0] tag, input logic [5:0] src,
                           input int stall);
        logic [63:0] got;
        int lat;
        send_flit(hdr(8'h14, 0, int'(src), tag));
        recv_flit(got, lat);
        check({name, "_ack_hdr"}, got, hdr(8'h94, 1, int'(src), tag));
        check({name, "_ack_lat"}, 64'(lat), 64'(WAIT_CYC + 1));
        repeat (stall) @(posedge clk);
        #1;
        recv_flit(got, lat);
        check({name, "_data"}, got, model_mem[idx(tag)]);
    endtask

    task automatic zero_model;
        for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = '0;
        model_err = 0;
    endtask

    initial begin
        logic [63:0] got, first;
        int lat, seen;

        rst = 1'b1;
        noc2_valid_in = 1'b0;
        noc2_data_in  = '0;
        noc3_ready_in = 1'b0;
        zero_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_ready", 64'(noc2_ready_out), 64'(0));
        check("rst_valid", 64'(noc3_valid_out), 64'(0));
        check("rst_data", noc3_data_out, 64'h0);
        check("rst_err", 64'(err_count), 64'(0));
        repeat (MEM_DEPTH - 1) @(posedge clk);
        @(negedge clk);
        check("zeroing_last_ready", 64'(noc2_ready_out), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("zeroing_done_ready", 64'(noc2_ready_out), 64'(1));
        @(posedge clk);
        #1;

        do_store("store3", 26'h3, 6'd5, 64'hDEAD_BEEF_0000_0001);
        do_load("load3", 26'h3, 6'd5, 0);

        // Backpressure on the ack header with a new request waiting upstream.
        send_flit(hdr(8'h14, 0, 9, 26'h3));
        noc3_ready_in = 1'b0;
        seen = 0;
        forever begin
            @(negedge clk);
            seen++;
            if (noc3_valid_out || seen > LIMIT) break;
        end
        check("stall_hdr_seen", 64'(noc3_valid_out), 64'(1));
        first = noc3_data_out;
        noc2_valid_in = 1'b1;
        noc2_data_in  = hdr(8'h14, 0, 9, 26'h4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hdr_stable", noc3_data_out, first);
            check("stall_no_accept", 64'(noc2_ready_out), 64'(0));
        end
        @(posedge clk);
        #1;
        noc2_valid_in = 1'b0;
        recv_flit(got, lat);
        check("stall_release_lat", 64'(lat), 64'(1));
        check("stall_hdr", got, hdr(8'h94, 1, 9, 26'h3));
        recv_flit(got, lat);
        check("stall_data", got, 64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        check("stall_single_resp", 64'(noc3_valid_out), 64'(0));
        @(posedge clk);
        #1;

        send_flit(hdr(8'h55, 3, 1, 26'h3));
        for (int i = 0; i < 3; i++) send_flit({$urandom, $urandom});
        model_err++;
        @(negedge clk);
        check("drop_err", 64'(err_count), 64'(model_err));
        check("drop_no_resp", 64'(noc3_valid_out), 64'(0));
        check("drop_idle_ready", 64'(noc2_ready_out), 64'(1));
        @(posedge clk);
        #1;
        do_load("after_drop", 26'h3, 6'd1, 0);

        send_flit(hdr(8'hA0, 0, 2, 26'h9));
        model_err++;
        @(negedge clk);
        check("zero_len_err", 64'(err_count), 64'(model_err));
        check("zero_len_ready", 64'(noc2_ready_out), 64'(1));
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            logic [25:0] tag;
            logic [5:0]  src;
            tag = 26'($urandom);
            src = 6'($urandom);
            if ($urandom_range(0, 1) == 0) do_store("rnd_store", tag, src, {$urandom, $urandom});
            else do_load("rnd_load", tag, src, int'($urandom_range(0, 3)));
        end

        do_store("alias_store", 26'h3, 6'd7, 64'h0123_4567_89AB_CDEF);
        do_load("alias_load", 26'h13, 6'd7, 1);

        for (int i = 0; i < 256; i++) begin
            send_flit(hdr(8'h55, 3, 0, 26'(i)));
            for (int j = 0; j < 3; j++) send_flit({$urandom, $urandom});
            model_err = (model_err < 255) ? model_err + 1 : 255;
        end
        @(negedge clk);
        check("err_saturated", 64'(err_count), 64'(model_err));
        @(posedge clk);
        #1;
        send_flit(hdr(8'h55, 0, 0, 26'h0));
        @(negedge clk);
        check("err_stays_255", 64'(err_count), 64'(255));
        @(posedge clk);
        #1;

        // Reset lands on the cycle the STORE payload would have transferred.
        send_flit(hdr(8'h13, 1, 2, 26'h7));
        noc2_valid_in = 1'b1;
        noc2_data_in  = 64'hBAD0_BAD0_BAD0_BAD0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        noc2_valid_in = 1'b0;
        zero_model();
        seen = 0;
        for (int i = 0; i < MEM_DEPTH + 8; i++) begin
            @(negedge clk);
            if (noc3_valid_out) seen++;
        end
        check("rst_mid_no_resp", 64'(seen), 64'(0));
        check("rst_mid_err", 64'(err_count), 64'(0));
        @(posedge clk);
        #1;
        do_load("rst_mid_load7", 26'h7, 6'd2, 0);
        do_load("rst_mid_load3", 26'h3, 6'd2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_mem_responder.md
L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 16, SHALL set the number of 64-bit backing-store entries (power of two, 2..256).
REQ-002 Parameter RESP_DELAY, default 4, SHALL set the response wait in cycles when MEM_RESP_DELAY_EN is defined (1..255).
REQ-003 Ports SHALL be as follows, with reset and clock already decided as "reset rst, synchronous, active-high; clock clk":
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- noc2_valid_in  in  1  request flit valid from L2 NoC2
- noc2_data_in  in  64  request flit
- noc2_ready_out  out  1  request flit accepted
- noc3_valid_out  out  1  response flit valid toward L2 NoC3
- noc3_data_out  out  64  response flit
- noc3_ready_in  in  1  L2 accepts response flit
- err_count  out  8  count of unknown-type requests (saturating)

Function
REQ-004 Header flit fields SHALL be: [7:0] type, [15:8] payload flit count, [21:16] source, [47:22] tag, [63:48] zero.
REQ-005 Request types SHALL be: STORE_MEM=8'h13 (1 payload flit) and LOAD_MEM=8'h14 (0 payload flits); response types SHALL be: STORE_MEM_ACK=8'h93 (0 payload) and LOAD_MEM_ACK=8'h94 (1 payload).
REQ-006 A flit SHALL transfer on any cycle where valid and ready are both high; noc3_data_out SHALL stay stable while noc3_valid_out=1 and noc3_ready_in=0.
REQ-007 The FSM SHALL have states IDLE, RX_DATA, DROP, WAIT, TX_HDR and TX_DATA.
REQ-008 In IDLE, noc2_ready_out=1; on a header transfer, the block SHALL latch the type, source and tag.
REQ-009 From IDLE, the next state SHALL be: RX_DATA for STORE_MEM; WAIT for LOAD_MEM; DROP for any other type with nonzero length; IDLE for any other type with zero length.
REQ-010 RX_DATA SHALL accept one flit and write it to entry tag[log2(MEM_DEPTH)-1:0] in the cycle that flit transfers, then go to WAIT.
REQ-011 DROP SHALL accept and discard exactly the payload count of flits, then go to IDLE; each unknown type SHALL increment err_count once, saturating at 255.
REQ-012 WAIT SHALL hold noc2_ready_out=0 and go to TX_HDR after the configured delay (REQ-020/021).
REQ-013 TX_HDR SHALL drive the ack header with the latched source and tag, and length 0 for STORE_MEM_ACK or 1 for LOAD_MEM_ACK. On transfer, STORE goes to IDLE and LOAD goes to TX_DATA.
REQ-014 TX_DATA SHALL drive the entry read for the latched tag, registered at the WAIT->TX_HDR transition, and go to IDLE on transfer.
REQ-015 noc2_ready_out SHALL be 1 only in IDLE, RX_DATA and DROP; noc3_valid_out SHALL be 1 only in TX_HDR and TX_DATA.
REQ-016 Exactly one request SHALL be outstanding; a new header is not accepted until the previous response has fully transferred.
REQ-017 A LOAD to an entry written by an earlier STORE SHALL return that STORE's data (read-after-write through the array).

Reset
REQ-018 On rst, the block SHALL set state=IDLE, noc3_valid_out=0, noc3_data_out=0, err_count=0 and the delay counter to 0. Array contents SHALL be zeroed over MEM_DEPTH cycles after reset, with noc2_ready_out=0 until zeroing completes.
REQ-019 rst asserted mid-transaction SHALL abandon the transaction with no response emitted; a partially received STORE SHALL NOT write the array.

Configuration
REQ-020 With MEM_RESP_DELAY_EN defined, WAIT SHALL last exactly RESP_DELAY cycles, counted by an 8-bit down-counter loaded on WAIT entry.
REQ-021 Without MEM_RESP_DELAY_EN, WAIT SHALL last exactly 1 cycle and no counter SHALL be instantiated.

Structure
REQ-022 Message type constants, the header field bit positions and the state enum SHALL reside in package l2_mem_pkg.
REQ-023 The backing store SHALL be sub-module mem_resp_array: one synchronous write port, one registered read port, and a reset-zeroing sequencer.

Verification
REQ-024 STORE_MEM, source 6'd5, tag 26'h0003, data 64'hDEAD_BEEF_0000_0001 -> one STORE_MEM_ACK with length 0, source 5, tag 3, issued RESP_DELAY+1 cycles after the data flit (2 cycles when the macro is undefined).
REQ-025 The same STORE then LOAD_MEM with tag 3 -> LOAD_MEM_ACK header (length 1) followed by data flit 64'hDEAD_BEEF_0000_0001.
REQ-026 noc3_ready_in held 0 for 10 cycles during TX_HDR -> header stable and no new request accepted; release -> single transfer.
REQ-027 Type 8'h55 with length 3 -> 3 payload flits consumed, no response, err_count=1; 256 such requests -> err_count=255.
REQ-028 rst pulsed during RX_DATA -> no response; a subsequent LOAD of that tag returns 0 after zeroing completes.
REQ-029 LOAD of tag 26'h0013 with MEM_DEPTH=16 -> aliases entry 3 (wrap-around on the index bits).
